dct_prod_accum: RTL and testbench
=================================

DCT_PROD_ACCUM -- requirements
Module: dct_prod_accum

Interface
REQ-001 Parameters SHALL be: PROD_W, default 36, product width; OUT_W, default 22, coefficient width; SHIFT, default 14, fixed-point scaling shift.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  single-cycle pulse: the upstream product FIFO holds a complete block of 16 products.
REQ-005 rd_en  output  1  registered read strobe to the upstream FIFO, one product per strobe.
REQ-006 prod_in  input  PROD_W  signed two's-complement product, valid exactly one cycle after each rd_en.
REQ-007 out_valid  output  1  registered qualifier for out_data and out_idx.
REQ-008 out_data  output  OUT_W  signed rounded, saturated coefficient.
REQ-009 out_idx  output  2  coefficient index 0..3 within the block.
REQ-010 block_done  output  1  one-cycle pulse coincident with the out_valid for out_idx=3.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 sat_flag  output  1  sticky; set when any coefficient of the current block saturates.

Function
REQ-013 FSM states SHALL be IDLE, READ and DRAIN.
- IDLE -> READ on the cycle start is sampled high.
- READ -> DRAIN after 16 rd_en cycles.
- DRAIN -> IDLE two cycles after entering DRAIN.
REQ-014 rd_en SHALL be high for exactly 16 consecutive cycles.
- It starts on the first cycle in READ.
- It is never high outside READ.
REQ-015 A 5-bit read counter SHALL count rd_en cycles 0..15; the READ-to-DRAIN transition occurs when the counter is 15 and rd_en is high.
REQ-016 Internal capture strobe cap_en SHALL equal rd_en delayed by one cycle; prod_in is sampled only when cap_en is high.
REQ-017 Accumulator SHALL be PROD_W+2 bits signed, with sign-extended addition.
REQ-018 Capture 4k+0 SHALL load the sign-extended prod_in (no addition); captures 4k+1..4k+3 SHALL add prod_in to the accumulator.
REQ-019 On the cycle after capture 4k+3, out_valid SHALL be 1 for one cycle with out_idx=k.
REQ-020 Coefficient arithmetic SHALL be:
- add 2^(SHIFT-1) to the accumulator;
- arithmetic right shift by SHIFT (round-half-up);
- clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-021 If the clamp is active for any coefficient, sat_flag SHALL set in the same cycle that coefficient's out_valid is high.
REQ-022 sat_flag SHALL clear only on reset or on an accepted start.
REQ-023 Latency SHALL be: start at cycle 0 -> first rd_en at cycle 1 -> last rd_en at cycle 16 -> out_valid for idx 0,1,2,3 at cycles 6,10,14,18 -> block_done at cycle 18 -> busy low at cycle 19.
REQ-024 start while busy=1 SHALL be ignored, with no effect on counters, outputs or sat_flag.
REQ-025 start on the cycle busy falls SHALL begin a new block normally, so back-to-back blocks are 19 cycles apart.
REQ-026 out_data and out_idx SHALL hold their last values while out_valid=0.
REQ-027 prod_in SHALL be ignored when cap_en=0, including X values.
REQ-028 The block SHALL NOT apply back-pressure; the downstream stage accepts out_valid unconditionally.

Reset
REQ-029 While rst=1, the block SHALL hold:
- state=IDLE, with counters and accumulator at 0;
- rd_en=0, out_valid=0, block_done=0, busy=0, sat_flag=0;
- out_data=0, out_idx=0.
REQ-030 Reset asserted mid-block SHALL abort the block immediately, with no partial out_valid after deassertion.
REQ-031 The first start accepted after reset SHALL behave exactly as in REQ-023.

Verification
REQ-032 Bench SHALL model the upstream FIFO, returning the nth queued product one cycle after each rd_en, and SHALL cover these scenarios:
- Nominal: all 16 products = 16384 -> out_data = 4,4,4,4 at cycles 6,10,14,18; block_done at 18; sat_flag=0.
- Rounding: group 0 products {8192,0,0,0} -> 1; group 1 {-8192,0,0,0} -> 0; group 2 {-8193,0,0,0} -> -1; group 3 {8191,0,0,0} -> 0.
- Saturation: group 0 products all 2^34 -> 2097151 with sat_flag=1; group 1 all -2^34 -> -2097152; sat_flag stays 1 until the next start.
- start pulsed at cycles 5 and 12 of an active block -> ignored; exactly 16 rd_en and 4 out_valid.
- rst asserted at cycle 9 -> all outputs at reset values asynchronously; no out_valid after release; a fresh start gives nominal timing.
- Back-to-back: second start on the cycle busy falls -> second block's out_valid at cycles 25,29,33,37 with correct values.

Source files
------------

// File: rtl/dct_prod_accum.sv
// dct_prod_accum: reads one block of 16 signed products from an upstream FIFO,
// sums them four at a time and emits four rounded, saturated coefficients.
// Each group sum gets a round-half-up rescale and a clamp to OUT_W bits.
// A sticky flag records whether any coefficient of the block was clamped.
module dct_prod_accum #(
    parameter int PROD_W = 36,
    parameter int OUT_W  = 22,
    parameter int SHIFT  = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     rd_en,
    input  logic signed [PROD_W-1:0] prod_in,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [1:0]               out_idx,
    output logic                     block_done,
    output logic                     busy,
    output logic                     sat_flag
);

    // The accumulator is two bits wider than a product so four products cannot overflow.
    localparam int ACC_W = PROD_W + 2;
    // One more bit so that adding the rounding constant cannot overflow.
    localparam int SUM_W = PROD_W + 3;

    localparam logic [4:0] RD_LAST = 5'd15;

    // Clamp limits, written out to the rescaled width for signed comparison.
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] LIM_HI = {{(SUM_W-OUT_W){1'b0}}, OUT_MAX};
    localparam logic signed [SUM_W-1:0] LIM_LO = {{(SUM_W-OUT_W){1'b1}}, OUT_MIN};
    localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(1) <<< (SHIFT-1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [4:0] rd_cnt_reg, rd_cnt_next;
    logic       drain_cnt_reg, drain_cnt_next;
    logic       rd_en_reg, rd_en_next;
    logic       start_accept;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic                     cap_en_reg;
    logic [3:0]               cap_cnt_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     out_valid_reg;
    logic signed [OUT_W-1:0]  out_data_reg;
    logic [1:0]               out_idx_reg;
    logic                     block_done_reg;
    logic                     sat_flag_reg;

    // Combinational datapath terms
    logic [1:0]               cap_phase;
    logic [1:0]               cap_group;
    logic                     group_done;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [SUM_W-1:0]  sum_ext;
    logic signed [SUM_W-1:0]  rounded;
    logic signed [SUM_W-1:0]  shifted;
    logic                     sat_hi;
    logic                     sat_lo;
    logic signed [OUT_W-1:0]  coef;

    // A start is only honoured from IDLE; starts seen while busy have no effect.
    assign start_accept = (state_reg == IDLE) && start;

    // State register and control counters; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rd_cnt_reg    <= 5'd0;
            drain_cnt_reg <= 1'b0;
            rd_en_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_cnt_reg    <= rd_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            rd_en_reg     <= rd_en_next;
        end
    end

    // Next-state logic; rd_en is registered so it is decided one cycle ahead.
    always_comb begin
        state_next     = state_reg;
        rd_cnt_next    = rd_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        rd_en_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = READ;
                    rd_cnt_next = 5'd0;
                    rd_en_next  = 1'b1;
                end
            end
            READ: begin
                if (rd_en_reg) begin
                    rd_cnt_next = rd_cnt_reg + 5'd1;
                end
                if (rd_en_reg && (rd_cnt_reg == RD_LAST)) begin
                    // Sixteenth strobe is on the bus now: stop reading.
                    state_next     = DRAIN;
                    drain_cnt_next = 1'b0;
                end else begin
                    rd_en_next = 1'b1;
                end
            end
            DRAIN: begin
                // Two cycles cover the final capture and the final coefficient.
                drain_cnt_next = drain_cnt_reg + 1'b1;
                if (drain_cnt_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_en = rd_en_reg;
    assign busy  = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Accumulate and rescale
    // ------------------------------------------------------------------
    assign cap_phase  = cap_cnt_reg[1:0];
    assign cap_group  = cap_cnt_reg[3:2];
    assign group_done = cap_en_reg && (cap_phase == 2'd3);

    assign prod_ext = {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};

    // The first product of each group restarts the sum instead of adding to it.
    assign acc_sum = (cap_phase == 2'd0) ? prod_ext : (acc_reg + prod_ext);

    // Round half up: add half an LSB of the output scale, then floor-shift.
    assign sum_ext = {acc_sum[ACC_W-1], acc_sum};
    assign rounded = sum_ext + ROUND_C;
    assign shifted = rounded >>> SHIFT;

    assign sat_hi = (shifted > LIM_HI);
    assign sat_lo = (shifted < LIM_LO);

    // Clamp to the signed OUT_W range.
    always_comb begin
        coef = shifted[OUT_W-1:0];
        if (sat_hi) begin
            coef = OUT_MAX;
        end else if (sat_lo) begin
            coef = OUT_MIN;
        end
    end

    // Capture strobe trails rd_en by one cycle to match the FIFO read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_en_reg  <= 1'b0;
            cap_cnt_reg <= 4'd0;
            acc_reg     <= '0;
        end else begin
            cap_en_reg <= rd_en_reg;
            if (start_accept) begin
                cap_cnt_reg <= 4'd0;
                acc_reg     <= '0;
            end else if (cap_en_reg) begin
                cap_cnt_reg <= cap_cnt_reg + 4'd1;
                acc_reg     <= acc_sum;
            end
        end
    end

    // Output register: the coefficient is presented the cycle after its fourth capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_idx_reg    <= 2'd0;
            block_done_reg <= 1'b0;
        end else begin
            out_valid_reg  <= group_done;
            block_done_reg <= group_done && (cap_group == 2'd3);
            if (group_done) begin
                out_data_reg <= coef;
                out_idx_reg  <= cap_group;
            end
        end
    end

    // Sticky saturation flag, cleared only when a new block is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag_reg <= 1'b0;
        end else if (start_accept) begin
            sat_flag_reg <= 1'b0;
        end else if (group_done && (sat_hi || sat_lo)) begin
            sat_flag_reg <= 1'b1;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_idx    = out_idx_reg;
    assign block_done = block_done_reg;
    assign sat_flag   = sat_flag_reg;

endmodule

// File: tb/tb_dct_prod_accum.sv
// Directed bench for dct_prod_accum: models the upstream FIFO, logs rd_en
// and out_valid events with cycle stamps, and checks them against hand-computed values.
module tb_dct_prod_accum;

    localparam int PW = 36;
    localparam int OW = 22;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic signed [PW-1:0] prod_in = '0;
    logic                 rd_en;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;
    logic [1:0]           out_idx;
    logic                 block_done;
    logic                 busy;
    logic                 sat_flag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int   cyc;
        int   data;
        int   idx;
        logic done;
        logic sat;
    } ov_t;

    longint fifo_q[$];
    int     rd_q[$];
    ov_t    ov_q[$];
    logic   rd_seen = 1'b0;
    int     stray_done = 0;

    dct_prod_accum #(.PROD_W(PW), .OUT_W(OW), .SHIFT(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rd_en      (rd_en),
        .prod_in    (prod_in),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .block_done (block_done),
        .busy       (busy),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event logger, sampled mid-cycle.
    always @(negedge clk) begin
        ov_t e;
        rd_seen = rd_en;
        if (rd_en) rd_q.push_back(cyc);
        if (out_valid) begin
            e.cyc  = cyc;
            e.data = int'(out_data);
            e.idx  = int'(out_idx);
            e.done = block_done;
            e.sat  = sat_flag;
            ov_q.push_back(e);
        end
        if (block_done && !out_valid) stray_done++;
    end

    // Upstream FIFO: next product appears one cycle after each rd_en, X otherwise.
    always @(posedge clk) begin
        #1;
        if (rd_seen && (fifo_q.size() > 0)) prod_in = PW'(fifo_q.pop_front());
        else prod_in = 'x;
    end

    task automatic tally(input bit ok, input string tag, input longint obs, input longint expv);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push4(input longint a, input longint b, input longint c, input longint d);
        fifo_q.push_back(a);
        fifo_q.push_back(b);
        fifo_q.push_back(c);
        fifo_q.push_back(d);
    endtask

    task automatic push_n(input longint v, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(v);
    endtask

    task automatic pulse_start(output int c0);
        @(posedge clk); #1;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && (n < 60)) begin
            @(negedge clk);
            n++;
        end
        tally(busy === 1'b0, "idle_timeout", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_block(input int c0,
                               input int e0, input int e1, input int e2, input int e3,
                               input logic s0, input logic s1, input logic s2, input logic s3);
        int   ed[4];
        logic es[4];
        int   r;
        int   nr;
        int   no;
        ov_t  e;
        ed[0] = e0; ed[1] = e1; ed[2] = e2; ed[3] = e3;
        es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
        tally(rd_q.size() >= 16, "rd_avail", rd_q.size(), 16);
        nr = (rd_q.size() < 16) ? rd_q.size() : 16;
        for (int i = 0; i < nr; i++) begin
            r = rd_q.pop_front();
            tally(r === (c0 + 1 + i), "rd_cycle", r, c0 + 1 + i);
        end
        tally(ov_q.size() >= 4, "ov_avail", ov_q.size(), 4);
        no = (ov_q.size() < 4) ? ov_q.size() : 4;
        for (int k = 0; k < no; k++) begin
            e = ov_q.pop_front();
            $display("block c0=%0d idx=%0d cyc=%0d data=%0d done=%0b sat=%0b",
                     c0, e.idx, e.cyc, e.data, e.done, e.sat);
            tally(e.cyc === (c0 + 6 + 4 * k), "ov_cycle", e.cyc, c0 + 6 + 4 * k);
            tally(e.idx === k, "ov_idx", e.idx, k);
            tally(e.data === ed[k], "ov_data", e.data, ed[k]);
            tally(e.done === (k == 3), "ov_done", e.done, (k == 3));
            tally(e.sat === es[k], "ov_sat", e.sat, es[k]);
        end
    endtask

    task automatic check_empty();
        tally(rd_q.size() === 0, "rd_extra", rd_q.size(), 0);
        tally(ov_q.size() === 0, "ov_extra", ov_q.size(), 0);
        tally(stray_done === 0, "stray_done", stray_done, 0);
    endtask

    initial begin
        int c0;
        int c1;

        // Reset state
        repeat (3) @(negedge clk);
        tally(rd_en === 1'b0, "rst_rd_en", rd_en, 0);
        tally(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
        tally(busy === 1'b0, "rst_busy", busy, 0);
        tally(sat_flag === 1'b0, "rst_sat", sat_flag, 0);
        tally(int'(out_data) === 0, "rst_data", out_data, 0);
        tally(int'(out_idx) === 0, "rst_idx", out_idx, 0);
        tally(block_done === 1'b0, "rst_done", block_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Nominal: sixteen products of 16384 give 4 per coefficient
        push_n(16384, 16);
        pulse_start(c0);
        wait_idle();
        check_block(c0, 4, 4, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        check_empty();
        tally(int'(out_data) === 4, "hold_data", out_data, 4);
        tally(int'(out_idx) === 3, "hold_idx", out_idx, 3);
        tally(out_valid === 1'b0, "hold_valid", out_valid, 0);

        // Rounding around the half-LSB boundary
        push4(8192, 0, 0, 0);
        push4(-8192, 0, 0, 0);
        push4(-8193, 0, 0, 0);
        push4(8191, 0, 0, 0);
        pulse_start(c0);
        wait_idle();
        check_block(c0, 1, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_empty();

        // Saturation both ways; flag is sticky past the end of the block
        push_n(64'sd17179869184, 4);
        push_n(-64'sd17179869184, 4);
        push_n(16384, 8);
        pulse_start(c0);
        wait_idle();
        check_block(c0, 2097151, -2097152, 4, 4, 1'b1, 1'b1, 1'b1, 1'b1);
        check_empty();
        tally(sat_flag === 1'b1, "sat_sticky", sat_flag, 1);

        // Starts at cycles 5 and 12 of an active block are ignored
        push_n(16384, 16);
        pulse_start(c0);
        tally(sat_flag === 1'b0, "sat_clear_on_start", sat_flag, 0);
        goto_cycle(c0 + 5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        goto_cycle(c0 + 12);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        check_block(c0, 4, 4, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        check_empty();

        // Reset at cycle 9 of a saturating block
        push_n(64'sd17179869184, 16);
        pulse_start(c0);
        goto_cycle(c0 + 9);
        tally(sat_flag === 1'b1, "pre_rst_sat", sat_flag, 1);
        rst = 1'b1;
        #1;
        tally(rd_en === 1'b0, "arst_rd_en", rd_en, 0);
        tally(out_valid === 1'b0, "arst_out_valid", out_valid, 0);
        tally(block_done === 1'b0, "arst_done", block_done, 0);
        tally(busy === 1'b0, "arst_busy", busy, 0);
        tally(sat_flag === 1'b0, "arst_sat", sat_flag, 0);
        tally(int'(out_data) === 0, "arst_data", out_data, 0);
        tally(int'(out_idx) === 0, "arst_idx", out_idx, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        fifo_q.delete();
        rd_q.delete();
        ov_q.delete();
        repeat (20) @(negedge clk);
        check_empty();
        push_n(16384, 16);
        pulse_start(c0);
        wait_idle();
        check_block(c0, 4, 4, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        check_empty();

        // Back-to-back: second start on the cycle busy falls
        push_n(16384, 16);
        push_n(-16384, 4);
        push4(32768, 32768, 0, 0);
        push4(100000, 0, 0, 0);
        push4(-100000, 0, 0, 0);
        pulse_start(c0);
        goto_cycle(c0 + 19);
        tally(busy === 1'b0, "b2b_busy_low", busy, 0);
        start = 1'b1;
        c1 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        check_block(c0, 4, 4, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        check_block(c1, -4, 4, 6, -6, 1'b0, 1'b0, 1'b0, 1'b0);
        check_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=%0d expected=%0d", cyc, 0);
        $fatal(1, "time limit reached");
    end

endmodule
